// File: rtl/bpred_btb.sv
// Direct-mapped branch target buffer with saturating direction counters, one register entry per index.
// Optional statistics counters are compiled in with `define BTB_STATS_EN.

module btb_entry #(
  parameter int ADDR_W   = 32,
  parameter int TAG_W    = 26,
  parameter int CNT_BITS = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                we,
  input  logic [TAG_W-1:0]    u_tag,
  input  logic                u_taken,
  input  logic [ADDR_W-1:0]   u_target,
  output logic                valid,
  output logic [TAG_W-1:0]    tag,
  output logic [ADDR_W-1:0]   target,
  output logic [CNT_BITS-1:0] cnt
);
  localparam logic [CNT_BITS-1:0] CNT_MAX = {CNT_BITS{1'b1}};
  localparam logic [CNT_BITS-1:0] CNT_WT  = CNT_BITS'(1 << (CNT_BITS-1));
  localparam logic [CNT_BITS-1:0] CNT_WNT = CNT_BITS'((1 << (CNT_BITS-1)) - 1);

  logic hit;
  assign hit = valid && (tag == u_tag);

  always_ff @(posedge clk) begin
    if (reset) begin
      valid  <= 1'b0;
      tag    <= '0;
      target <= '0;
      cnt    <= CNT_WNT;
    end else if (we) begin
      if (hit) begin
        if (u_taken) begin
          if (cnt != CNT_MAX) cnt <= cnt + 1'b1;
          target <= u_target;
        end else if (cnt != '0) begin
          cnt <= cnt - 1'b1;
        end
      end else if (u_taken) begin
        // Direct-mapped: a taken miss evicts whatever occupies the slot
        valid  <= 1'b1;
        tag    <= u_tag;
        target <= u_target;
        cnt    <= CNT_WT;
      end
    end
  end
endmodule

module bpred_btb #(
  parameter int ADDR_W   = 32,
  parameter int ENTRIES  = 16,
  parameter int CNT_BITS = 2,
  parameter int STAT_W   = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              lookup_valid,
  input  logic [ADDR_W-1:0] lookup_pc,
  output logic              pred_hit,
  output logic              pred_taken,
  output logic [ADDR_W-1:0] pred_target,
  input  logic              upd_valid,
  input  logic [ADDR_W-1:0] upd_pc,
  input  logic              upd_taken,
  input  logic [ADDR_W-1:0] upd_target,
  input  logic              upd_pred_taken,
  input  logic [ADDR_W-1:0] upd_pred_target,
  output logic              mispredict,
  output logic [STAT_W-1:0] stat_lookups,
  output logic [STAT_W-1:0] stat_updates,
  output logic [STAT_W-1:0] stat_mispred
);
  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_W = ADDR_W - IDX_W - 2;

  logic [IDX_W-1:0] l_idx, u_idx;
  logic [TAG_W-1:0] l_tag, u_tag;

  assign l_idx = lookup_pc[IDX_W+1:2];
  assign l_tag = lookup_pc[ADDR_W-1:IDX_W+2];
  assign u_idx = upd_pc[IDX_W+1:2];
  assign u_tag = upd_pc[ADDR_W-1:IDX_W+2];

  logic [ENTRIES-1:0]               e_valid;
  logic [ENTRIES-1:0][TAG_W-1:0]    e_tag;
  logic [ENTRIES-1:0][ADDR_W-1:0]   e_target;
  logic [ENTRIES-1:0][CNT_BITS-1:0] e_cnt;

  for (genvar i = 0; i < ENTRIES; i++) begin : g_ent
    btb_entry #(.ADDR_W(ADDR_W), .TAG_W(TAG_W), .CNT_BITS(CNT_BITS)) u_ent (
      .clk      (clk),
      .reset    (reset),
      .we       (upd_valid && (u_idx == IDX_W'(i))),
      .u_tag    (u_tag),
      .u_taken  (upd_taken),
      .u_target (upd_target),
      .valid    (e_valid[i]),
      .tag      (e_tag[i]),
      .target   (e_target[i]),
      .cnt      (e_cnt[i])
    );
  end

  // Lookup reads current flops, so a same-cycle update to the slot is seen next cycle
  assign pred_hit    = e_valid[l_idx] && (e_tag[l_idx] == l_tag);
  assign pred_taken  = pred_hit && e_cnt[l_idx][CNT_BITS-1];
  assign pred_target = pred_taken ? e_target[l_idx] : lookup_pc + ADDR_W'(4);

  assign mispredict = upd_valid &&
                      ((upd_taken != upd_pred_taken) ||
                       (upd_taken && upd_pred_taken && (upd_target != upd_pred_target)));

`ifdef BTB_STATS_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      stat_lookups <= '0;
      stat_updates <= '0;
      stat_mispred <= '0;
    end else begin
      if (lookup_valid && (stat_lookups != '1)) stat_lookups <= stat_lookups + 1'b1;
      if (upd_valid && (stat_updates != '1))    stat_updates <= stat_updates + 1'b1;
      if (mispredict && (stat_mispred != '1))   stat_mispred <= stat_mispred + 1'b1;
    end
  end
`else
  assign stat_lookups = '0;
  assign stat_updates = '0;
  assign stat_mispred = '0;
`endif

  // Byte-offset bits never select an entry; lookup_valid only feeds the statistics
  logic unused_ok;
  assign unused_ok = &{1'b0, lookup_valid, lookup_pc[1:0], upd_pc[1:0]};
endmodule

// File: tb/tb_bpred_btb.sv
// Directed scoreboard bench for bpred_btb (ENTRIES=16, CNT_BITS=2); stats expectations follow BTB_STATS_EN.

module tb_bpred_btb;
  logic        clk = 1'b0;
  logic        reset;
  logic        lookup_valid;
  logic [31:0] lookup_pc;
  logic        pred_hit, pred_taken;
  logic [31:0] pred_target;
  logic        upd_valid;
  logic [31:0] upd_pc;
  logic        upd_taken;
  logic [31:0] upd_target;
  logic        upd_pred_taken;
  logic [31:0] upd_pred_target;
  logic        mispredict;
  logic [31:0] stat_lookups, stat_updates, stat_mispred;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        hit;
    logic        taken;
    logic [31:0] tgt;
    logic [31:0] pc;
  } lk_t;

  lk_t  lk_q[$];
  logic mp_q[$];

  bpred_btb dut (
    .clk             (clk),
    .reset           (reset),
    .lookup_valid    (lookup_valid),
    .lookup_pc       (lookup_pc),
    .pred_hit        (pred_hit),
    .pred_taken      (pred_taken),
    .pred_target     (pred_target),
    .upd_valid       (upd_valid),
    .upd_pc          (upd_pc),
    .upd_taken       (upd_taken),
    .upd_target      (upd_target),
    .upd_pred_taken  (upd_pred_taken),
    .upd_pred_target (upd_pred_target),
    .mispredict      (mispredict),
    .stat_lookups    (stat_lookups),
    .stat_updates    (stat_updates),
    .stat_mispred    (stat_mispred)
  );

  always #5 clk = ~clk;

  // Monitor: compares outputs at the falling edge against queued expectations
  always @(negedge clk) begin
    if (lookup_valid) begin
      checks++;
      if (lk_q.size() == 0) begin
        errors++;
        $display("FAIL lookup pc=%h: no expectation queued", lookup_pc);
      end else begin
        lk_t e;
        e = lk_q.pop_front();
        if (pred_hit !== e.hit || pred_taken !== e.taken || pred_target !== e.tgt) begin
          errors++;
          $display("FAIL lookup pc=%h: got hit=%b taken=%b tgt=%h, want hit=%b taken=%b tgt=%h",
                   e.pc, pred_hit, pred_taken, pred_target, e.hit, e.taken, e.tgt);
        end
      end
    end
    checks++;
    if (upd_valid) begin
      if (mp_q.size() == 0) begin
        errors++;
        $display("FAIL mispredict pc=%h: no expectation queued", upd_pc);
      end else begin
        logic em;
        em = mp_q.pop_front();
        if (mispredict !== em) begin
          errors++;
          $display("FAIL mispredict pc=%h: got %b, want %b", upd_pc, mispredict, em);
        end
      end
    end else if (mispredict !== 1'b0) begin
      errors++;
      $display("FAIL mispredict_gated: got %b, want 0", mispredict);
    end
  end

  task automatic lk(input logic [31:0] pc, input logic h, input logic t, input logic [31:0] tgt);
    lk_t e;
    lookup_valid = 1'b1;
    lookup_pc    = pc;
    e.hit = h; e.taken = t; e.tgt = tgt; e.pc = pc;
    lk_q.push_back(e);
  endtask

  task automatic up(input logic [31:0] pc, input logic tk, input logic [31:0] tgt,
                    input logic pt, input logic [31:0] ptgt, input logic mp);
    upd_valid       = 1'b1;
    upd_pc          = pc;
    upd_taken       = tk;
    upd_target      = tgt;
    upd_pred_taken  = pt;
    upd_pred_target = ptgt;
    mp_q.push_back(mp);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
    lookup_valid = 1'b0;
    upd_valid    = 1'b0;
  endtask

  task automatic chk_stats(input int el, input int eu, input int em);
    checks++;
    if (stat_lookups !== 32'(el) || stat_updates !== 32'(eu) || stat_mispred !== 32'(em)) begin
      errors++;
      $display("FAIL stats: got %0d/%0d/%0d, want %0d/%0d/%0d",
               stat_lookups, stat_updates, stat_mispred, el, eu, em);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; lookup_valid = 1'b0; lookup_pc = '0;
    upd_valid = 1'b0; upd_pc = '0; upd_taken = 1'b0; upd_target = '0;
    upd_pred_taken = 1'b0; upd_pred_target = '0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    chk_stats(0, 0, 0);

    // Cold lookups, including wrap at the top of the address space
    lk(32'h40, 0, 0, 32'h44);                     tick();
    lk(32'hFFFF_FFFC, 0, 0, 32'h0);               tick();
    // Allocate; same-cycle lookup still misses
    lk(32'h40, 0, 0, 32'h44); up(32'h40, 1, 32'h100, 0, 32'h44, 1); tick();
    lk(32'h40, 1, 1, 32'h100); up(32'h40, 1, 32'h100, 1, 32'h100, 0); tick();  // cnt 2->3
    lk(32'h40, 1, 1, 32'h100); up(32'h40, 1, 32'h100, 1, 32'h104, 1); tick();  // target mismatch
    lk(32'h40, 1, 1, 32'h100); up(32'h40, 1, 32'h100, 1, 32'h100, 0); tick();  // stays 3
    // Decay; not-taken updates must not touch the target
    lk(32'h40, 1, 1, 32'h100); up(32'h40, 0, 32'hBAD0, 1, 32'h100, 1); tick(); // 3->2
    lk(32'h40, 1, 1, 32'h100); up(32'h40, 0, 32'hBAD0, 1, 32'h100, 1); tick(); // 2->1
    // Hazard: lookup sees counter 1, update lifts it to 2 with a new target
    lk(32'h40, 1, 0, 32'h44); up(32'h40, 1, 32'h180, 0, 32'h44, 1); tick();
    lk(32'h40, 1, 1, 32'h180);                    tick();
    // Not-taken miss leaves state alone
    lk(32'h84, 0, 0, 32'h88); up(32'h84, 0, 32'h300, 0, 32'h88, 0); tick();
    lk(32'h84, 0, 0, 32'h88);                     tick();
    // Alias 0x440 onto index 0, evicting 0x40
    lk(32'h440, 0, 0, 32'h444); up(32'h440, 1, 32'h200, 0, 32'h444, 1); tick();
    lk(32'h40, 0, 0, 32'h44);                     tick();
    lk(32'h440, 1, 1, 32'h200);                   tick();
    // Saturate at zero, then one taken step lands on 1 (not taken)
    up(32'h440, 0, 32'h0, 1, 32'h200, 1);         tick();
    lk(32'h440, 1, 0, 32'h444); up(32'h440, 0, 32'h0, 0, 32'h0, 0); tick();
    up(32'h440, 0, 32'h0, 0, 32'h0, 0);           tick();
    up(32'h440, 1, 32'h200, 0, 32'h444, 1);       tick();
    lk(32'h440, 1, 0, 32'h444);                   tick();

    // Statistics phase from a fresh reset
    reset = 1'b1; tick(); reset = 1'b0;
    chk_stats(0, 0, 0);
    lk(32'h40, 0, 0, 32'h44); up(32'h40, 1, 32'h300, 0, 32'h44, 1);   tick();
    lk(32'h40, 1, 1, 32'h300); up(32'h40, 1, 32'h300, 1, 32'h300, 0); tick();
    lk(32'h40, 1, 1, 32'h300); up(32'h40, 0, 32'h0, 1, 32'h300, 1);   tick();
    lk(32'h40, 1, 1, 32'h300);                    tick();
    lk(32'h8, 0, 0, 32'hC);                       tick();
`ifdef BTB_STATS_EN
    chk_stats(5, 3, 2);
`else
    chk_stats(0, 0, 0);
`endif
    // Reset with a live update: update is dropped, everything cleared
    reset = 1'b1; up(32'h8, 1, 32'h400, 0, 32'hC, 1); tick(); reset = 1'b0;
    chk_stats(0, 0, 0);
    lk(32'h40, 0, 0, 32'h44);                     tick();
    lk(32'h8, 0, 0, 32'hC);                       tick();

    checks++;
    if (lk_q.size() != 0 || mp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d lookup and %0d update expectations left, want 0/0",
               lk_q.size(), mp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/bpred_btb.md
Name: bpred_btb

Overview:
- Parametrised branch target buffer with per-entry saturating direction counters for the pipelined MIPS core.
- It predicts in IF, so fetch can redirect without waiting for the stage-2/stage-4 branch resolve.
- The resolving stage feeds outcomes back through an update port. The core flushes on the block's mispredict flag instead of on every taken branch.
- Successor to the fixed "always not-taken plus flush" scheme. Adds depth, counter-width generalisation and statistics.

Parameters:
- ADDR_W, 32: PC and target width.
- ENTRIES, 16: number of BTB entries; power of two, 2..256. IDX_W = log2(ENTRIES).
- CNT_BITS, 2: direction counter width, 1..4.
- STAT_W, 32: statistics counter width (used only with the optional feature).

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- lookup_valid  in  1  IF stage presents a fetch PC this cycle
- lookup_pc  in  ADDR_W  fetch PC
- pred_hit  out  1  valid entry with matching tag
- pred_taken  out  1  predicted taken
- pred_target  out  ADDR_W  predicted next PC
- upd_valid  in  1  a branch or jump resolved this cycle
- upd_pc  in  ADDR_W  PC of the resolved branch
- upd_taken  in  1  actual outcome
- upd_target  in  ADDR_W  actual taken target
- upd_pred_taken  in  1  prediction that was piped with the branch
- upd_pred_target  in  ADDR_W  predicted target that was piped with the branch
- mispredict  out  1  prediction was wrong; core flushes and redirects
- stat_lookups  out  STAT_W  optional feature only
- stat_updates  out  STAT_W  optional feature only
- stat_mispred  out  STAT_W  optional feature only

Behaviour:
- Address split:
  - index = pc[IDX_W+1:2]
  - tag = pc[ADDR_W-1:IDX_W+2]
  - pc[1:0] is ignored.
- Entry state: valid (1 bit), tag, target (ADDR_W), counter (CNT_BITS). Held in registers, not RAM.
- Lookup is combinational from lookup_pc, with zero-cycle latency:
  - pred_hit = valid[idx] & (tag[idx] == tag(lookup_pc)).
  - pred_taken = pred_hit & counter[idx] MSB.
  - pred_target = pred_taken ? target[idx] : lookup_pc + 4, modulo 2^ADDR_W (wraps at the top of the address space).
- Outputs are independent of lookup_valid. lookup_valid affects the statistics only.
- mispredict is combinational and gated by upd_valid:
  - mispredict = upd_valid & ((upd_taken != upd_pred_taken) | (upd_taken & upd_pred_taken & (upd_target != upd_pred_target))).
- Update is applied at the rising edge when upd_valid = 1 and reset = 0. u_idx and u_tag come from upd_pc.
- Hit, i.e. valid and tag match:
  - taken: counter increments, saturating at 2^CNT_BITS-1; target <= upd_target.
  - not taken: counter decrements, saturating at 0; target is unchanged.
- Miss and taken: allocate, overwriting any occupant (direct-mapped):
  - valid <= 1, tag <= u_tag, target <= upd_target.
  - counter <= 2^(CNT_BITS-1), i.e. weakly taken.
- Miss and not taken: no state change.
- Simultaneous lookup and update to the same index: the lookup sees pre-update state (read-before-write). The new state is visible from the next cycle.
- Reset, synchronous:
  - All valid <= 0.
  - All counters <= 2^(CNT_BITS-1)-1 (weakly not-taken). When CNT_BITS = 1 this is 0.
  - Tags and targets <= 0.
  - An update presented in the reset cycle is discarded.
- Values just after reset:
  - pred_hit = 0, pred_taken = 0, pred_target = lookup_pc + 4.
  - mispredict follows its inputs, since it is combinational.
- Reset mid-operation: all learned state is lost. No partial update survives.

Optional Feature:
- Macro: BTB_STATS_EN.
- With the macro defined, three STAT_W-bit saturating counters are added. All reset to 0, and none wraps.
  - stat_lookups: increments each cycle with lookup_valid = 1.
  - stat_updates: increments each cycle with upd_valid = 1.
  - stat_mispred: increments each cycle with mispredict = 1.
- Without the macro, the three stat ports are driven constant 0 and no counter flops are synthesised.

Test Plan:
- Cold lookup: reset, then lookup_pc = 0x0000_0040 -> pred_hit = 0, pred_taken = 0, pred_target = 0x0000_0044.
- Allocate:
  - upd pc = 0x40, taken, target = 0x100, pred_taken = 0 -> mispredict = 1 in the same cycle.
  - Next cycle, lookup 0x40 -> hit = 1, taken = 1 (counter = 2), target = 0x100.
- Saturation and decay, CNT_BITS = 2:
  - Three more taken updates on 0x40 -> counter = 3, stays 3.
  - Then two not-taken -> counter = 1, and lookup 0x40 gives pred_taken = 0 with pred_target = 0x44.
- Alias, ENTRIES = 16:
  - Taken update on pc 0x80 (index 0, same as 0x40's index 0... use 0x40 vs 0x440) -> 0x440 allocates with target 0x200.
  - After that, lookup 0x40 -> pred_hit = 0.
- Same-cycle hazard: lookup and update on 0x40 in one cycle -> the lookup reflects the old counter; the next-cycle lookup reflects the new one.
- Reset and stats:
  - With BTB_STATS_EN defined, run 5 lookups, 3 updates and 2 mispredicts -> stat = 5/3/2.
  - Assert reset mid-stream together with upd_valid -> all stats = 0, next lookup misses.
  - Build without the macro -> stats stay 0.
